mips_pipe_ctrl: RTL and testbench

//   Parametrised pipeline-control unit for the N-stage MIPS core.

---
 rtl/mips_pipe_ctrl_pkg.sv | 24 ++
 rtl/mips_pipe_ctrl_if.sv | 34 +++
 rtl/mips_step_sync.sv | 27 ++
 rtl/mips_pipe_ctrl.sv | 147 ++++++++++++++
 tb/tb_mips_pipe_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_pipe_ctrl_pkg.sv
// Shared types for the pipeline-control unit: debug FSM states and stall-cause codes.
package mips_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PcRun  = 2'd0,
    PcHalt = 2'd1,
    PcStep = 2'd2
  } pc_state_e;

  // Winning hazard for the current cycle, highest priority first.
  typedef enum logic [2:0] {
    CauseNone     = 3'd0,
    CauseFreeze   = 3'd1,
    CauseLoadUse  = 3'd2,
    CauseBranch   = 3'd3,
    CauseInstWait = 3'd4
  } stall_cause_e;

  // A redirect is not a stall even when the fetch is also waiting.
  function automatic logic is_stall(input stall_cause_e cause);
    return (cause == CauseFreeze) || (cause == CauseLoadUse) || (cause == CauseInstWait);
  endfunction

endpackage

// File: rtl/mips_pipe_ctrl_if.sv
// Hazard/handshake inputs and stage-control/counter outputs of the pipeline-control unit.
interface mips_pipe_ctrl_if #(
  parameter int unsigned STAGES = 5,
  parameter int unsigned CNT_W  = 32
);

  logic              debug_en;
  logic              debug_step;
  logic              load_use;
  logic              branch_taken;
  logic              inst_ack;
  logic              mem_req;
  logic              mem_ack;
  logic [STAGES-1:0] stage_en;
  logic [STAGES-1:0] stage_rst;
  logic [STAGES-1:0] stage_valid;
  logic              halted;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  retire_cnt;

  // Core datapath side.
  modport master (
    output debug_en, debug_step, load_use, branch_taken, inst_ack, mem_req, mem_ack,
    input  stage_en, stage_rst, stage_valid, halted, cycle_cnt, stall_cnt, retire_cnt
  );

  // Pipeline-control side.
  modport slave (
    input  debug_en, debug_step, load_use, branch_taken, inst_ack, mem_req, mem_ack,
    output stage_en, stage_rst, stage_valid, halted, cycle_cnt, stall_cnt, retire_cnt
  );

endinterface

// File: rtl/mips_step_sync.sv
// Two-flop synchroniser for the debug step button followed by a rising-edge pulse.
module mips_step_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/mips_pipe_ctrl.sv
// Pipeline-control unit: per-stage enable/bubble/valid vectors, debug run/halt/step FSM
// and saturating performance counters for the N-stage MIPS core.
module mips_pipe_ctrl
  import mips_pipe_ctrl_pkg::*;
#(
  parameter int unsigned STAGES  = 5,
  parameter int unsigned ID_STG  = 1,
  parameter int unsigned BR_STG  = 1,
  parameter int unsigned MEM_STG = 3,
  parameter int unsigned CNT_W   = 32
) (
  input logic             i_clk,
  input logic             i_rst_n,
  mips_pipe_ctrl_if.slave io_bus
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  pc_state_e         r_state;
  pc_state_e         w_state_d;
  stall_cause_e      w_cause;
  logic              w_go;
  logic              w_freeze;
  logic              w_step_pulse;
  logic [STAGES-1:0] w_en;
  logic [STAGES-1:0] w_rst;
  logic [STAGES-1:0] w_prev;
  logic [STAGES-1:0] w_valid_d;
  logic [STAGES-1:0] r_valid;
  logic [CNT_W-1:0]  r_cycle_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_retire_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != CntMax)) ? v + CntOne : v;
  endfunction

  mips_step_sync u_step_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (io_bus.debug_step),
    .o_pulse (w_step_pulse)
  );

  assign w_go     = (r_state == PcRun) || (r_state == PcStep);
  assign w_freeze = r_valid[MEM_STG] & io_bus.mem_req & ~io_bus.mem_ack;

  always_comb begin
    w_cause = CauseNone;
    if (w_freeze) begin
      w_cause = CauseFreeze;
    end else if (io_bus.load_use) begin
      w_cause = CauseLoadUse;
    end else if (io_bus.branch_taken) begin
      w_cause = CauseBranch;
    end else if (!io_bus.inst_ack) begin
      w_cause = CauseInstWait;
    end
  end

  // Bubbles go only into the stage that would otherwise receive the withheld instruction.
  always_comb begin
    w_en  = '0;
    w_rst = '0;
    if (!i_rst_n) begin
      w_rst = '1;
    end else if (w_go) begin
      unique case (w_cause)
        CauseFreeze: begin
          w_en = '0;
        end
        CauseLoadUse: begin
          for (int unsigned i = 0; i < STAGES; i++) begin
            w_en[i]  = (i > ID_STG);
            w_rst[i] = (i == ID_STG + 1);
          end
        end
        CauseBranch: begin
          w_en = '1;
          for (int unsigned i = 0; i < STAGES; i++) begin
            w_rst[i] = (i >= 1) && (i <= BR_STG);
          end
        end
        CauseInstWait: begin
          w_en     = '1;
          w_en[0]  = 1'b0;
          w_rst[1] = 1'b1;
        end
        default: begin
          w_en = '1;
        end
      endcase
    end
  end

  // Stage 0 always takes a real instruction from the fetch side.
  assign w_prev    = {r_valid[STAGES-2:0], 1'b1};
  assign w_valid_d = ~w_rst & ((w_en & w_prev) | (~w_en & r_valid));

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      PcRun: begin
        if (io_bus.debug_en) w_state_d = PcHalt;
      end
      PcHalt: begin
        if (!io_bus.debug_en) begin
          w_state_d = PcRun;
        end else if (w_step_pulse) begin
          w_state_d = PcStep;
        end
      end
      PcStep: begin
        if (w_cause != CauseFreeze) w_state_d = io_bus.debug_en ? PcHalt : PcRun;
      end
      default: begin
        w_state_d = PcRun;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= PcRun;
      r_valid      <= '0;
      r_cycle_cnt  <= '0;
      r_stall_cnt  <= '0;
      r_retire_cnt <= '0;
    end else begin
      r_state      <= w_state_d;
      r_valid      <= w_valid_d;
      r_cycle_cnt  <= sat_inc(r_cycle_cnt, w_go);
      r_stall_cnt  <= sat_inc(r_stall_cnt, w_go & is_stall(w_cause));
      r_retire_cnt <= sat_inc(r_retire_cnt, r_valid[STAGES-1] & w_en[STAGES-1]);
    end
  end

  assign io_bus.stage_en    = w_en;
  assign io_bus.stage_rst   = w_rst;
  assign io_bus.stage_valid = r_valid;
  assign io_bus.halted      = (r_state == PcHalt);
  assign io_bus.cycle_cnt   = r_cycle_cnt;
  assign io_bus.stall_cnt   = r_stall_cnt;
  assign io_bus.retire_cnt  = r_retire_cnt;

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// Directed bench for mips_pipe_ctrl: default 5-stage instance plus a CNT_W=4 copy for saturation.
module tb_mips_pipe_ctrl;

  logic clk;
  logic rst_n;
  logic debug_en, debug_step, load_use, branch_taken, inst_ack, mem_req, mem_ack;
  int   n_tests = 0;
  int   n_fail  = 0;

  mips_pipe_ctrl_if #(.STAGES(5), .CNT_W(32)) u_if ();
  mips_pipe_ctrl_if #(.STAGES(5), .CNT_W(4))  s_if ();

  assign u_if.debug_en     = debug_en;
  assign u_if.debug_step   = debug_step;
  assign u_if.load_use     = load_use;
  assign u_if.branch_taken = branch_taken;
  assign u_if.inst_ack     = inst_ack;
  assign u_if.mem_req      = mem_req;
  assign u_if.mem_ack      = mem_ack;
  assign s_if.debug_en     = debug_en;
  assign s_if.debug_step   = debug_step;
  assign s_if.load_use     = load_use;
  assign s_if.branch_taken = branch_taken;
  assign s_if.inst_ack     = inst_ack;
  assign s_if.mem_req      = mem_req;
  assign s_if.mem_ack      = mem_ack;

  mips_pipe_ctrl #(.STAGES(5), .ID_STG(1), .BR_STG(1), .MEM_STG(3), .CNT_W(32)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (u_if)
  );

  mips_pipe_ctrl #(.STAGES(5), .ID_STG(1), .BR_STG(1), .MEM_STG(3), .CNT_W(4)) u_sat (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    debug_en = 1'b0; debug_step = 1'b0; load_use = 1'b0; branch_taken = 1'b0;
    inst_ack = 1'b1; mem_req = 1'b0; mem_ack = 1'b1;

    // Reset state
    #3;
    chk("rst_valid", u_if.stage_valid, 5'b00000);
    chk("rst_en", u_if.stage_en, 5'b00000);
    chk("rst_rst", u_if.stage_rst, 5'b11111);
    chk("rst_halted", u_if.halted, 1'b0);
    chk("rst_cycle", u_if.cycle_cnt, 0);
    chk("rst_retire", u_if.retire_cnt, 0);
    #5 rst_n = 1'b1;
    #1;
    chk("first_en", u_if.stage_en, 5'b11111);
    chk("first_rst", u_if.stage_rst, 5'b00000);

    // Fill
    tick(1);
    chk("fill_v0", u_if.stage_valid, 5'b00001);
    tick(4);
    chk("fill_full", u_if.stage_valid, 5'b11111);
    chk("fill_cycle", u_if.cycle_cnt, 5);
    tick(5);
    chk("fill_retire", u_if.retire_cnt, 5);
    chk("fill_cycle10", u_if.cycle_cnt, 10);
    chk("fill_stall", u_if.stall_cnt, 0);

    // Load-use
    load_use = 1'b1;
    #1;
    chk("lu_en", u_if.stage_en, 5'b11100);
    chk("lu_rst", u_if.stage_rst, 5'b00100);
    tick(1);
    load_use = 1'b0;
    chk("lu_valid", u_if.stage_valid, 5'b11011);
    chk("lu_stall", u_if.stall_cnt, 1);
    chk("lu_retire", u_if.retire_cnt, 6);

    // Data-memory freeze for 3 cycles
    mem_req = 1'b1; mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("frz_en", u_if.stage_en, 5'b00000);
      chk("frz_rst", u_if.stage_rst, 5'b00000);
      tick(1);
      chk("frz_valid", u_if.stage_valid, 5'b11011);
    end
    chk("frz_stall", u_if.stall_cnt, 4);
    chk("frz_cycle", u_if.cycle_cnt, 14);
    chk("frz_retire", u_if.retire_cnt, 6);
    mem_ack = 1'b1;
    #1;
    chk("frz_rel_en", u_if.stage_en, 5'b11111);
    tick(1);
    mem_req = 1'b0;
    chk("frz_rel_valid", u_if.stage_valid, 5'b10111);
    chk("frz_rel_retire", u_if.retire_cnt, 7);

    // Branch taken
    branch_taken = 1'b1;
    #1;
    chk("br_en", u_if.stage_en, 5'b11111);
    chk("br_rst", u_if.stage_rst, 5'b00010);
    tick(1);
    branch_taken = 1'b0;
    chk("br_valid", u_if.stage_valid, 5'b01101);
    chk("br_retire", u_if.retire_cnt, 8);

    // Instruction-memory wait
    inst_ack = 1'b0;
    #1;
    chk("iw_en", u_if.stage_en, 5'b11110);
    chk("iw_rst", u_if.stage_rst, 5'b00010);
    tick(1);
    chk("iw_valid", u_if.stage_valid, 5'b11001);
    chk("iw_stall", u_if.stall_cnt, 5);

    // Branch with inst wait: PC still loads the target
    branch_taken = 1'b1;
    #1;
    chk("briw_en", u_if.stage_en, 5'b11111);
    chk("briw_rst", u_if.stage_rst, 5'b00010);
    tick(1);
    branch_taken = 1'b0; inst_ack = 1'b1;
    chk("briw_valid", u_if.stage_valid, 5'b10001);
    chk("briw_retire", u_if.retire_cnt, 9);
    chk("briw_cycle", u_if.cycle_cnt, 18);

    // Refill
    tick(5);
    chk("refill_valid", u_if.stage_valid, 5'b11111);
    chk("refill_retire", u_if.retire_cnt, 11);
    chk("refill_cycle", u_if.cycle_cnt, 23);

    // Halt
    debug_en = 1'b1;
    tick(1);
    #1;
    chk("halt_halted", u_if.halted, 1'b1);
    chk("halt_en", u_if.stage_en, 5'b00000);
    chk("halt_rst", u_if.stage_rst, 5'b00000);
    chk("halt_cycle", u_if.cycle_cnt, 24);
    tick(1);
    chk("halt_hold_cycle", u_if.cycle_cnt, 24);

    // Step through a 2-cycle data-memory wait
    mem_req = 1'b1; mem_ack = 1'b0; debug_step = 1'b1;
    tick(1);
    debug_step = 1'b0;
    tick(1);
    chk("step_sync_halted", u_if.halted, 1'b1);
    tick(1);
    chk("step_halted", u_if.halted, 1'b0);
    chk("step_frz_en", u_if.stage_en, 5'b00000);
    chk("step_cycle0", u_if.cycle_cnt, 24);
    tick(2);
    chk("step_still", u_if.halted, 1'b0);
    mem_ack = 1'b1;
    #1;
    chk("step_adv_en", u_if.stage_en, 5'b11111);
    tick(1);
    mem_req = 1'b0;
    chk("step_back_halted", u_if.halted, 1'b1);
    chk("step_back_en", u_if.stage_en, 5'b00000);
    chk("step_cycle", u_if.cycle_cnt, 27);
    chk("step_retire", u_if.retire_cnt, 13);
    tick(2);
    chk("step_once_retire", u_if.retire_cnt, 13);

    // Resume and saturate the narrow copy
    debug_en = 1'b0;
    tick(1);
    chk("resume_halted", u_if.halted, 1'b0);
    tick(5);
    chk("run_retire", u_if.retire_cnt, 18);
    chk("run_cycle", u_if.cycle_cnt, 32);
    chk("sat_cycle", s_if.cycle_cnt, 4'hF);
    chk("sat_retire", s_if.retire_cnt, 4'hF);

    // Async reset mid-run
    #2 rst_n = 1'b0;
    #1;
    chk("rerst_valid", u_if.stage_valid, 5'b00000);
    chk("rerst_cycle", u_if.cycle_cnt, 0);
    chk("rerst_rst", u_if.stage_rst, 5'b11111);
    chk("rerst_sat", s_if.cycle_cnt, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
